// File: rtl/lcd_qc12864b_reader.sv
// Read-side bus engine for the QC12864B (ST7920) parallel LCD: status (BF+AC) and data reads, with busy polling.
// Optional build macro LCD_BUSY_TIMEOUT_EN bounds busy polling at MAX_POLLS status reads.
module lcd_qc12864b_reader #(
    parameter int T_AS      = 5,
    parameter int T_PW      = 25,
    parameter int T_REC     = 25,
    parameter int MAX_POLLS = 1000
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_busy,
    output logic [6:0] rsp_ac,
    output logic       rsp_timeout,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    input  logic [7:0] lcd_data_i,
    output logic       lcd_data_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_RECOV,
        S_DONE
    } state_t;

    localparam logic [15:0] AS_LOAD  = 16'(T_AS - 1);
    localparam logic [15:0] PW_LOAD  = 16'(T_PW - 1);
    localparam logic [15:0] REC_LOAD = 16'(T_REC - 1);

    if (T_AS < 1 || T_PW < 1 || T_REC < 1 || MAX_POLLS < 1) begin : g_param_check
        $error("lcd_qc12864b_reader: timing parameters and MAX_POLLS must be >= 1");
    end

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic        rs_q, poll_q, first_q;
    logic [7:0]  sample;

    logic accept, cnt_zero, recov_end, busy_retry, timeout_hit, load_rsp;

    assign accept      = (state == S_IDLE) && req_ready && req_valid;
    assign cnt_zero    = (cnt == 16'd0);
    assign recov_end   = (state == S_RECOV) && cnt_zero;
    assign busy_retry  = !rs_q && poll_q && sample[7];
    assign lcd_data_oe = 1'b0;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        load_rsp = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SETUP;
                    cnt_d   = AS_LOAD;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_EHIGH;
                    cnt_d   = PW_LOAD;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            S_EHIGH: begin
                if (cnt_zero) begin
                    state_d = S_RECOV;
                    cnt_d   = REC_LOAD;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            S_RECOV: begin
                if (!cnt_zero) begin
                    cnt_d = cnt - 16'd1;
                end else if ((rs_q && first_q) || (busy_retry && !timeout_hit)) begin
                    // ST7920 dummy read, or controller still busy: run another bus cycle.
                    state_d = S_SETUP;
                    cnt_d   = AS_LOAD;
                end else begin
                    state_d  = S_DONE;
                    load_rsp = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge mclk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, because the response fields have defined reset values.
            state     <= S_IDLE;
            cnt       <= 16'd0;
            rs_q      <= 1'b0;
            poll_q    <= 1'b0;
            first_q   <= 1'b0;
            sample    <= 8'h00;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_busy  <= 1'b0;
            rsp_ac    <= 7'h00;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b1;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            req_ready <= (state_d == S_IDLE);
            rsp_valid <= (state_d == S_DONE);
            lcd_e     <= (state_d == S_EHIGH);
            lcd_rw    <= 1'b1;
            if (accept) begin
                rs_q    <= req_rs;
                poll_q  <= req_poll;
                first_q <= 1'b1;
                lcd_rs  <= req_rs;
            end
            if (state == S_EHIGH && cnt_zero) begin
                sample <= lcd_data_i;
            end
            if (recov_end) begin
                first_q <= 1'b0;
            end
            if (load_rsp) begin
                rsp_data <= sample;
                rsp_busy <= !rs_q && sample[7];
                rsp_ac   <= rs_q ? 7'h00 : sample[6:0];
            end
        end
    end

`ifdef LCD_BUSY_TIMEOUT_EN
    localparam int PCW = $clog2(MAX_POLLS + 1);

    // Counts status reads that have already returned BF=1 in the current request.
    logic [PCW-1:0] poll_cnt;

    assign timeout_hit = (poll_cnt == PCW'(MAX_POLLS - 1));

    always_ff @(posedge mclk) begin
        if (rst) begin
            poll_cnt    <= '0;
            rsp_timeout <= 1'b0;
        end else if (accept) begin
            poll_cnt    <= '0;
            rsp_timeout <= 1'b0;
        end else if (recov_end && busy_retry) begin
            if (timeout_hit) begin
                rsp_timeout <= 1'b1;
            end else begin
                poll_cnt <= poll_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_qc12864b_reader.sv
// Scoreboard bench for lcd_qc12864b_reader: a bus model feeds LCD bytes, a request-level model predicts each response.
module tb_lcd_qc12864b_reader;

    localparam int T_AS  = 5;
    localparam int T_PW  = 25;
    localparam int T_REC = 25;
    localparam int MAXP  = 4;
    localparam int L     = 1 + T_AS + T_PW + T_REC;
`ifdef LCD_BUSY_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       mclk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic       req_poll;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_busy;
    logic [6:0] rsp_ac;
    logic       rsp_timeout;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data_i;
    logic       lcd_data_oe;

    lcd_qc12864b_reader #(
        .T_AS(T_AS), .T_PW(T_PW), .T_REC(T_REC), .MAX_POLLS(MAXP)
    ) dut (
        .mclk(mclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_poll(req_poll),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_busy(rsp_busy), .rsp_ac(rsp_ac),
        .rsp_timeout(rsp_timeout),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data_i(lcd_data_i), .lcd_data_oe(lcd_data_oe)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       busy;
        logic [6:0] ac;
        logic       to;
        int         lat;
        int         pulses;
        int         acc_cyc;
        int         pulse_start;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic       rs;
    } bus_t;

    exp_t       exp_q[$];
    bus_t       bus_q[$];
    logic [7:0] stim_bytes[$];

    int n_checks     = 0;
    int n_fail       = 0;
    int pulse_total  = 0;
    int last_rsp_cyc = -10;
    bit abort        = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // LCD bus model: presents the next queued byte on each E rise and checks the strobe.
    initial begin : bus_model
        logic e_prev;
        int   width;
        logic cur_rs;
        bus_t t;
        e_prev     = 1'b0;
        width      = 0;
        cur_rs     = 1'b0;
        lcd_data_i = 8'h00;
        forever begin
            @(negedge mclk);
            if (lcd_e && !e_prev) begin
                pulse_total++;
                width = 1;
                check("e_rise_rw", lcd_rw, 1);
                if (bus_q.size() > 0) begin
                    t          = bus_q.pop_front();
                    lcd_data_i = t.b;
                    cur_rs     = t.rs;
                    check("e_rise_rs", lcd_rs, t.rs);
                end else begin
                    check("bus_underrun", bus_q.size(), 1);
                end
            end else if (lcd_e) begin
                width++;
            end else if (e_prev && !abort) begin
                check("e_width", width, T_PW);
                check("e_fall_rs", lcd_rs, cur_rs);
            end
            e_prev = lcd_e;
        end
    end

    // Response monitor: pops the prediction for every rsp_valid pulse.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge mclk);
            if (rsp_valid) begin
                check("rsp_oe", lcd_data_oe, 0);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_busy", rsp_busy, e.busy);
                    check("rsp_ac", rsp_ac, e.ac);
                    check("rsp_timeout", rsp_timeout, e.to);
                    check("rsp_latency", cyc - e.acc_cyc, e.lat);
                    check("rsp_pulses", pulse_total - e.pulse_start, e.pulses);
                    last_rsp_cyc = cyc;
                end
            end
        end
    end

    // Predicts the response from the reply bytes in stim_bytes, then issues the request.
    task automatic issue(input bit rs, input bit poll, input bit b2b, input bit record);
        exp_t       e;
        bus_t       bt;
        int         n;
        int         k;
        bit         to;
        logic [7:0] last;
        n  = 1;
        to = 1'b0;
        if (rs) begin
            n = 2;
        end else if (poll) begin
            n = 0;
            while (n < stim_bytes.size() && stim_bytes[n][7]) n++;
            n++;
            if (TO_EN && n > MAXP) begin
                n  = MAXP;
                to = 1'b1;
            end
        end
        last     = stim_bytes[n-1];
        e.data   = last;
        e.busy   = rs ? 1'b0 : last[7];
        e.ac     = rs ? 7'h00 : last[6:0];
        e.to     = to;
        e.lat    = n * L - (n - 1);
        e.pulses = n;
        for (int i = 0; i < n; i++) begin
            bt.b  = stim_bytes[i];
            bt.rs = rs;
            bus_q.push_back(bt);
        end
        req_valid = 1'b1;
        req_rs    = rs;
        req_poll  = poll;
        k = 0;
        while (!req_ready && k < 2000) begin
            @(negedge mclk);
            k++;
        end
        if (!req_ready) begin
            check("accept_timeout", k, 0);
        end else begin
            e.acc_cyc     = cyc;
            e.pulse_start = pulse_total;
            if (record) exp_q.push_back(e);
            if (b2b) check("b2b_accept", cyc, last_rsp_cyc + 1);
        end
        @(negedge mclk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 5000) begin
            @(negedge mclk);
            k++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic rand_bytes(input bit rs, input bit poll);
        int nb;
        stim_bytes.delete();
        if (rs) begin
            stim_bytes.push_back(8'($urandom));
            stim_bytes.push_back(8'($urandom));
        end else if (poll) begin
            nb = $urandom_range(0, 5);
            for (int i = 0; i < nb; i++) stim_bytes.push_back(8'($urandom) | 8'h80);
            stim_bytes.push_back(8'($urandom) & 8'h7F);
        end else begin
            stim_bytes.push_back(8'($urandom));
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int k;
        bit rs;
        bit poll;
        bit gap;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_poll  = 1'b0;
        repeat (3) @(negedge mclk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_busy", rsp_busy, 0);
        check("rst_rsp_ac", rsp_ac, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_lcd_e", lcd_e, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 1);
        check("rst_lcd_oe", lcd_data_oe, 0);
        rst = 1'b0;
        @(negedge mclk);
        check("ready_after_rst", req_ready, 1);

        stim_bytes = {8'h1A};
        issue(1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        stim_bytes = {8'hAA, 8'hCE};
        issue(1'b1, 1'b0, 1'b0, 1'b1);
        drain();
        stim_bytes = {8'h85, 8'h85, 8'h05};
        issue(1'b0, 1'b1, 1'b0, 1'b1);
        drain();
        stim_bytes = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
        if (TO_EN) begin
            issue(1'b0, 1'b1, 1'b0, 1'b1);
            drain();
        end

        // Two status reads with the request held high across the response.
        stim_bytes = {8'h3C};
        issue(1'b0, 1'b0, 1'b0, 1'b1);
        stim_bytes = {8'h47};
        issue(1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // Reset in the middle of the first E-high window of a data read.
        stim_bytes = {8'h11, 8'h22};
        issue(1'b1, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (!lcd_e && k < 100) begin
            @(negedge mclk);
            k++;
        end
        check("abort_e_high", lcd_e, 1);
        repeat (3) @(negedge mclk);
        abort = 1'b1;
        rst   = 1'b1;
        @(negedge mclk);
        check("abort_lcd_e", lcd_e, 0);
        check("abort_req_ready", req_ready, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge mclk);
        bus_q.delete();
        rst = 1'b0;
        @(negedge mclk);
        check("abort_ready_after", req_ready, 1);
        abort = 1'b0;
        repeat (150) @(negedge mclk);

        gap = 1'b1;
        for (int t = 0; t < 24; t++) begin
            rs   = 1'($urandom);
            poll = 1'($urandom);
            rand_bytes(rs, poll);
            issue(rs, poll, !gap, 1'b1);
            gap = ($urandom_range(0, 2) != 0);
            if (gap) repeat ($urandom_range(1, 4)) @(negedge mclk);
        end
        drain();
        check("bus_queue_empty", bus_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
